// File: rtl/mc_defs.sv
// Shared definitions for the multicycle datapath: control FSM state codes, the
// opcode constants decoded by the controller, and the ALU/mux select codes. Also
// used by alu_control and the datapath top.
//
// Contents:
//   state_e      - FSM state codes, FETCH=0 .. JUMP=11
//   Op*          - instruction[31:26] opcodes
//   AluOp*       - ALUOp encodings seen by alu_control
//   SrcB*        - ALUSrcB mux selects
//   PcSrc*       - PCSource mux selects
//   ctrl_t       - packed control vector produced by mc_output_decode
//   isMemState() - states whose duration is stretched by the memory wait counter
package mc_defs;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'd0;
    localparam logic [5:0] OpLw    = 6'd35;
    localparam logic [5:0] OpSw    = 6'd43;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpAddi  = 6'd8;
    localparam logic [5:0] OpJ     = 6'd2;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBSext   = 2'b10;
    localparam logic [1:0] SrcBSextSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    function automatic logic isMemState(state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode for the multicycle controller: maps the current state and
// the "final cycle of this state" flag onto the datapath control vector.
// Anything not set for a state stays 0.
//
// Ports:
//   state_i     - current FSM state
//   lastCycle_i - 1 in the final cycle of the state (always 1 for single-cycle states)
//   ctrl_o      - control vector
module mc_output_decode
    import mc_defs::*;
(
    input  state_e state_i,
    input  logic   lastCycle_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StFetch: begin
                ctrl_o.memRead  = 1'b1;
                ctrl_o.aluSrcB  = SrcBFour;
                ctrl_o.aluOp    = AluOpAdd;
                ctrl_o.pcSource = PcSrcAlu;
                // IR and PC update only once the memory word is actually there.
                ctrl_o.irWrite  = lastCycle_i;
                ctrl_o.pcWrite  = lastCycle_i;
            end
            StDecode: begin
                // Speculative branch target: PC + (signext << 2).
                ctrl_o.aluSrcB = SrcBSextSh;
                ctrl_o.aluOp   = AluOpAdd;
            end
            StMemAdr, StAddiEx: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SrcBSext;
                ctrl_o.aluOp   = AluOpAdd;
            end
            StMemRd: begin
                ctrl_o.memRead = 1'b1;
                ctrl_o.iorD    = 1'b1;
            end
            StMemWb: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memtoReg = 1'b1;
            end
            StMemWr: begin
                ctrl_o.iorD     = 1'b1;
                ctrl_o.memWrite = lastCycle_i;
            end
            StExec: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SrcBReg;
                ctrl_o.aluOp   = AluOpFunct;
            end
            StRwb: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.regDst   = 1'b1;
            end
            StBranch: begin
                ctrl_o.aluSrcA     = 1'b1;
                ctrl_o.aluSrcB     = SrcBReg;
                ctrl_o.aluOp       = AluOpSub;
                ctrl_o.pcWriteCond = 1'b1;
                ctrl_o.pcSource    = PcSrcAluOut;
            end
            StAddiWb: begin
                ctrl_o.regWrite = 1'b1;
            end
            StJump: begin
                ctrl_o.pcWrite  = 1'b1;
                ctrl_o.pcSource = PcSrcJump;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the classic multicycle MIPS datapath. Memory-access states
// (FETCH, MEMRD, MEMWR) are stretched by MEM_LAT wait cycles using a 4-bit
// counter; all other states last one cycle.
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   opcode              - instruction[31:26] from the IR, looked at in DECODE/MEMADR only
//   PCWrite..ALUSrcA    - 1-bit datapath strobes and mux selects
//   ALUSrcB, ALUOp,
//   PCSource            - 2-bit mux selects / ALU operation class
//   state               - current state code (debug)
//   illegal_op          - one-cycle pulse after DECODE saw an unsupported opcode
module multicycle_control
    import mc_defs::*;
#(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [3:0] MemLatCnt = 4'(MEM_LAT);

    state_e     stateQ, stateD;
    logic [3:0] waitCntQ, waitCntD;
    logic       illegalQ, illegalD;
    logic       lastCycle;
    state_e     decState;
    ctrl_t      decCtrl;
    ctrl_t      ctrl;

    assign lastCycle = isMemState(stateQ) ? (waitCntQ == MemLatCnt) : 1'b1;

    always_comb begin
        stateD   = stateQ;
        illegalD = 1'b0;
        if (lastCycle) begin
            unique case (stateQ)
                StFetch: stateD = StDecode;
                StDecode: begin
                    case (opcode)
                        OpLw, OpSw: stateD = StMemAdr;
                        OpRtype:    stateD = StExec;
                        OpBeq:      stateD = StBranch;
                        OpAddi:     stateD = StAddiEx;
                        OpJ:        stateD = StJump;
                        default: begin
                            stateD   = StFetch;
                            illegalD = 1'b1;
                        end
                    endcase
                end
                StMemAdr: begin
                    if (opcode == OpSw) begin
                        stateD = StMemWr;
                    end else if (opcode == OpLw) begin
                        stateD = StMemRd;
                    end else begin
                        stateD = StFetch;
                    end
                end
                StMemRd:  stateD = StMemWb;
                StExec:   stateD = StRwb;
                StAddiEx: stateD = StAddiWb;
                default:  stateD = StFetch;
            endcase
        end
    end

    // Every state is left on its last cycle, so clearing there restarts the count
    // on entry to the next state.
    assign waitCntD = lastCycle ? 4'd0 : waitCntQ + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StFetch;
            waitCntQ <= 4'd0;
            illegalQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
            illegalQ <= illegalD;
        end
    end

    // While reset is held the outputs look like FETCH with every strobe off.
    assign decState = reset ? StFetch : stateQ;

    mc_output_decode uDecode (
        .state_i     (decState),
        .lastCycle_i (lastCycle),
        .ctrl_o      (decCtrl)
    );

    always_comb begin
        ctrl = decCtrl;
        if (reset) begin
            ctrl.pcWrite     = 1'b0;
            ctrl.pcWriteCond = 1'b0;
            ctrl.irWrite     = 1'b0;
            ctrl.regWrite    = 1'b0;
            ctrl.memWrite    = 1'b0;
            ctrl.memRead     = 1'b0;
        end
    end

    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign IorD        = ctrl.iorD;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign IRWrite     = ctrl.irWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign RegDst      = ctrl.regDst;
    assign RegWrite    = ctrl.regWrite;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign ALUSrcB     = ctrl.aluSrcB;
    assign ALUOp       = ctrl.aluOp;
    assign PCSource    = ctrl.pcSource;
    assign state       = decState;
    assign illegal_op  = illegalQ & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Three instances (MEM_LAT = 0, 2, 3)
// share clock, reset and opcode; each step checks the selected instance.
// Expected per-cycle {state, control vector, illegal_op} records are queued when
// an instruction is issued and popped one per cycle.
// Control vector bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
// MemtoReg RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0].
module tb_multicycle_control;

    localparam logic [15:0] CFetchWait = 16'h1010;
    localparam logic [15:0] CFetchLast = 16'h9410;
    localparam logic [15:0] CDecode    = 16'h0030;
    localparam logic [15:0] CMemAdr    = 16'h0060;
    localparam logic [15:0] CMemRd     = 16'h3000;
    localparam logic [15:0] CMemWb     = 16'h0280;
    localparam logic [15:0] CMemWrWait = 16'h2000;
    localparam logic [15:0] CMemWrLast = 16'h2800;
    localparam logic [15:0] CExec      = 16'h0048;
    localparam logic [15:0] CRwb       = 16'h0180;
    localparam logic [15:0] CBranch    = 16'h4045;
    localparam logic [15:0] CAddiEx    = 16'h0060;
    localparam logic [15:0] CAddiWb    = 16'h0080;
    localparam logic [15:0] CJump      = 16'h8002;
    localparam logic [15:0] CReset     = 16'h0010;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;

    logic [15:0] obsCtl [3];
    logic [3:0]  obsSt  [3];
    logic        obsIll [3];

    int    vectors = 0;
    int    miscompares = 0;
    int    sel = 0;
    bit    pendIll = 1'b0;
    string tag = "init";
    exp_t  expQ [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        localparam int unsigned Lat = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
        logic [1:0] srcb, aluop, pcsrc;
        logic [3:0] st;

        multicycle_control #(.MEM_LAT(Lat)) uDut (
            .clk         (clk),
            .reset       (reset),
            .opcode      (opcode),
            .PCWrite     (pcw),
            .PCWriteCond (pcwc),
            .IorD        (iord),
            .MemRead     (mrd),
            .MemWrite    (mwr),
            .IRWrite     (irw),
            .MemtoReg    (m2r),
            .RegDst      (rdst),
            .RegWrite    (rw),
            .ALUSrcA     (srca),
            .ALUSrcB     (srcb),
            .ALUOp       (aluop),
            .PCSource    (pcsrc),
            .state       (st),
            .illegal_op  (ill)
        );

        assign obsCtl[g] = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop,
                            pcsrc};
        assign obsSt[g]  = st;
        assign obsIll[g] = ill;
    end

    function automatic void push(input logic [3:0] s, input logic [15:0] c, input logic i);
        exp_t e;
        e.st  = s;
        e.ctl = c;
        e.ill = i;
        expQ.push_back(e);
    endfunction

    function automatic void pushFetch(input int lat);
        for (int i = 0; i <= lat; i++) begin
            push(4'd0, (i == lat) ? CFetchLast : CFetchWait, (i == 0) && pendIll);
        end
        pendIll = 1'b0;
    endfunction

    // One clock cycle: compare at the falling edge, then move to just after the
    // next rising edge where the caller may change inputs.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $error("FAIL %s sb_underflow: got empty scoreboard, required an entry", tag);
        end else begin
            e = expQ.pop_front();
            assert ({obsSt[sel], obsCtl[sel], obsIll[sel]} === e) else begin
                miscompares++;
                $error("FAIL %s: state/ctl/ill got %0d/%h/%b required %0d/%h/%b", tag,
                       obsSt[sel], obsCtl[sel], obsIll[sel], e.st, e.ctl, e.ill);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse(input int s);
        reset   = 1'b1;
        sel     = s;
        pendIll = 1'b0;
        expQ.delete();
        push(4'd0, CReset, 1'b0);
        cyc();
        push(4'd0, CReset, 1'b0);
        cyc();
        reset = 1'b0;
    endtask

    // Issue one instruction; once opcode is no longer meant to be looked at it is
    // scrambled to show later states ignore it.
    task automatic doInstr(input logic [5:0] op, input int lat);
        int n;
        int garble;
        opcode = op;
        pushFetch(lat);
        push(4'd1, CDecode, 1'b0);
        case (op)
            6'd35: begin
                push(4'd2, CMemAdr, 1'b0);
                for (int i = 0; i <= lat; i++) push(4'd3, CMemRd, 1'b0);
                push(4'd4, CMemWb, 1'b0);
            end
            6'd43: begin
                push(4'd2, CMemAdr, 1'b0);
                for (int i = 0; i <= lat; i++) push(4'd5, (i == lat) ? CMemWrLast : CMemWrWait, 1'b0);
            end
            6'd0: begin
                push(4'd6, CExec, 1'b0);
                push(4'd7, CRwb, 1'b0);
            end
            6'd8: begin
                push(4'd9, CAddiEx, 1'b0);
                push(4'd10, CAddiWb, 1'b0);
            end
            6'd4:    push(4'd8, CBranch, 1'b0);
            6'd2:    push(4'd11, CJump, 1'b0);
            default: pendIll = 1'b1;
        endcase
        garble = (op == 6'd35 || op == 6'd43) ? lat + 2 : lat + 1;
        n = expQ.size();
        for (int k = 0; k < n; k++) begin
            cyc();
            if (k == garble) opcode = 6'h3f;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 ns, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        // MEM_LAT = 0
        tag = "reset_lat0";
        resetPulse(0);
        tag = "lw_lat0";
        doInstr(6'd35, 0);
        tag = "sw_lat0";
        doInstr(6'd43, 0);
        tag = "beq_lat0";
        doInstr(6'd4, 0);
        tag = "j_lat0";
        doInstr(6'd2, 0);
        tag = "illegal_lat0";
        doInstr(6'd63, 0);
        tag = "seq_rtype";
        doInstr(6'd0, 0);
        tag = "seq_addi";
        doInstr(6'd8, 0);
        tag = "seq_lw";
        doInstr(6'd35, 0);

        // MEM_LAT = 2
        tag = "reset_lat2";
        resetPulse(1);
        tag = "sw_lat2";
        doInstr(6'd43, 2);
        tag = "beq_lat2";
        doInstr(6'd4, 2);
        tag = "lw_lat2";
        doInstr(6'd35, 2);

        // MEM_LAT = 3, reset in the second MEMRD cycle
        tag = "reset_lat3";
        resetPulse(2);
        tag = "lw_cut_lat3";
        opcode = 6'd35;
        pushFetch(3);
        push(4'd1, CDecode, 1'b0);
        push(4'd2, CMemAdr, 1'b0);
        push(4'd3, CMemRd, 1'b0);
        for (int k = 0; k < 7; k++) cyc();
        tag = "midwait_reset";
        reset = 1'b1;
        push(4'd0, CReset, 1'b0);
        cyc();
        push(4'd0, CReset, 1'b0);
        cyc();
        reset = 1'b0;
        tag = "addi_after_reset";
        doInstr(6'd8, 3);
        tag = "lw_lat3";
        doInstr(6'd35, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
